// File: rtl/im_loader.sv
// Streams a program into instruction memory, holds the core in reset while
// loading, then releases it after a fixed settling period.
module im_loader #(
  parameter int ADDR_W      = 10,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_IDX = DEPTH - 1'b1;

  // The hold counter only has to reach HOLD_CYCLES-1, loaded on entry to HOLD.
  localparam int              HC_W      = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  logic [1:0]      state;
  logic [HC_W-1:0] hold_cnt;
  logic            accept;

  assign s_ready    = (state == LOAD);
  assign accept     = s_valid && s_ready;
  assign core_reset = (state != RUN);
  assign load_done  = (state == RUN);
  assign load_err   = (state == ERR);

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // im_addr below relies on that to capture the pre-increment word_count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      hold_cnt   <= '0;
      word_count <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
    end else begin
      im_we <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            im_we    <= 1'b1;
            im_addr  <= word_count[ADDR_W-1:0];
            im_wdata <= s_data;
            if (word_count != DEPTH) begin
              word_count <= word_count + 1'b1;
            end
            if (s_last) begin
              state    <= HOLD;
              hold_cnt <= HOLD_INIT;
            end else if (word_count == LAST_IDX) begin
              state <= ERR;
            end
          end
        end
        HOLD: begin
          if (reload) begin
            state      <= LOAD;
            word_count <= '0;
            hold_cnt   <= '0;
          end else if (hold_cnt == '0) begin
            state <= RUN;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          // RUN and ERR only leave on an explicit reload.
          if (reload) begin
            state      <= LOAD;
            word_count <= '0;
            hold_cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomised bench for im_loader: a cycle-count reference model feeds a
// scoreboard of expected memory writes that a negedge monitor drains.
module tb_im_loader;

  localparam int ADDR_W = 2;
  localparam int HOLD   = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              s_valid;
  logic [31:0]       s_data;
  logic              s_last;
  logic              s_ready;
  logic              reload;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              core_reset;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   word_count;

  im_loader #(.ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .reload     (reload),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: loading accepts any valid beat; a last beat schedules the
  // core release HOLD edges later; filling DEPTH words without last is an error.
  bit m_loading;
  bit m_err;
  int m_release;
  int m_count;
  int cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 1'b1;
      m_err     = 1'b0;
      m_release = -1;
      m_count   = 0;
      exp_q.delete();
    end else begin
      cyc++;
      if (reload && !m_loading) begin
        m_loading = 1'b1;
        m_err     = 1'b0;
        m_release = -1;
        m_count   = 0;
      end else if (m_loading && s_valid) begin
        exp_q.push_back('{addr: ADDR_W'(m_count), data: s_data});
        m_count++;
        if (s_last) begin
          m_loading = 1'b0;
          m_release = cyc + HOLD;
        end else if (m_count == DEPTH) begin
          m_loading = 1'b0;
          m_err     = 1'b1;
        end
      end
    end
  end

  // Monitor: one write expected per queued entry, outputs compared every cycle.
  logic [ADDR_W-1:0] last_addr;
  logic [31:0]       last_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_addr = '0;
      last_data = '0;
    end else begin
      bit released;
      released = (m_release >= 0) && (cyc >= m_release);
      check("s_ready",    64'(s_ready),    64'(m_loading));
      check("core_reset", 64'(core_reset), 64'(!released));
      check("load_done",  64'(load_done),  64'(released));
      check("load_err",   64'(load_err),   64'(m_err));
      check("word_count", 64'(word_count), 64'(m_count));
      check("im_we",      64'(im_we),      64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        wr_t w;
        w         = exp_q.pop_front();
        last_addr = w.addr;
        last_data = w.data;
      end
      check("im_addr",  64'(im_addr),  64'(last_addr));
      check("im_wdata", 64'(im_wdata), 64'(last_data));
    end
  end

  task automatic drive(input bit v, input logic [31:0] d, input bit l, input bit rl);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    reload  = rl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_im_we"},      64'(im_we),      64'(0));
    check({tag, "_im_addr"},    64'(im_addr),    64'(0));
    check({tag, "_im_wdata"},   64'(im_wdata),   64'(0));
    check({tag, "_word_count"}, 64'(word_count), 64'(0));
    check({tag, "_core_reset"}, 64'(core_reset), 64'(1));
    check({tag, "_load_done"},  64'(load_done),  64'(0));
    check({tag, "_load_err"},   64'(load_err),   64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] prog [3];
    prog[0] = 32'h3C01_0000;
    prog[1] = 32'h3421_0001;
    prog[2] = 32'h0000_0000;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; reload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three-word program with valid held high.
    for (int i = 0; i < 3; i++) drive(1'b1, prog[i], i == 2, 1'b0);
    idle(7);
    check("prog3_count", 64'(word_count), 64'(3));
    check("prog3_done",  64'(load_done),  64'(1));

    // Same program with valid toggling every cycle.
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, prog[i], i == 2, 1'b0);
      drive(1'b0, $urandom, 1'b0, 1'b0);
    end
    idle(7);
    check("toggle_count", 64'(word_count), 64'(3));

    // Overflow into ERR, a fifth word, then ten cycles of ignored traffic.
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, $urandom, $urandom_range(0, 1) == 1, 1'b0);
    check("ovf_err",   64'(load_err),   64'(1));
    check("ovf_count", 64'(word_count), 64'(DEPTH));

    // Exactly DEPTH words with last on the final one, then ignored traffic in RUN.
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, i == DEPTH - 1, 1'b0);
    idle(7);
    for (int i = 0; i < 10; i++) drive(1'b1, $urandom, $urandom_range(0, 1) == 1, 1'b0);
    check("full_done", 64'(load_done), 64'(1));
    check("full_err",  64'(load_err),  64'(0));

    // Reload from RUN with a single all-ones word.
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle(7);
    check("one_count", 64'(word_count), 64'(1));

    // Asynchronous reset in the middle of a five-word load.
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    drive(1'b1, 32'h2222_2222, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'h3333_3333;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h4444_4444, 1'b0, 1'b0);
    drive(1'b1, 32'h5555_5555, 1'b1, 1'b0);
    idle(7);

    // Random traffic, including reloads in every state.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) == 0,
            $urandom_range(0, 24) == 0);
    end
    idle(3);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the instruction memory (DEPTH = 2**ADDR_W words).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, number of cycles core_reset stays asserted after the last word is written.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port s_valid, input, 1, a program word is offered on s_data.
REQ-006 SHALL have port s_data, input, 32, program word.
REQ-007 SHALL have port s_last, input, 1, the offered word is the final program word.
REQ-008 SHALL have port s_ready, output, 1, the loader accepts a word this cycle.
REQ-009 SHALL have port reload, input, 1, single-cycle request to restart loading.
REQ-010 SHALL have port im_we, output, 1, instruction-memory write enable.
REQ-011 SHALL have port im_addr, output, ADDR_W, instruction-memory word address.
REQ-012 SHALL have port im_wdata, output, 32, instruction-memory write data.
REQ-013 SHALL have port core_reset, output, 1, active-high reset driven to the mips core.
REQ-014 SHALL have port load_done, output, 1, program loaded and core released.
REQ-015 SHALL have port load_err, output, 1, program exceeded DEPTH words.
REQ-016 SHALL have port word_count, output, ADDR_W+1, number of words written in the current load.

Function
REQ-017 SHALL implement states LOAD, HOLD, RUN, ERR; s_ready = 1 only in LOAD (combinational from state).
REQ-018 A beat SHALL be accepted when s_valid && s_ready at a rising edge; no other input combination writes memory.
REQ-019 On an accepted beat, the next cycle SHALL show im_we=1, im_addr=word_count (pre-increment value), im_wdata=s_data; word_count SHALL increment by 1 (one-cycle registered write latency).
REQ-020 im_we SHALL be 1 for exactly one cycle per accepted beat and 0 in every other cycle; im_addr/im_wdata hold their last value while im_we=0.
REQ-021 LOAD -> HOLD SHALL occur on an accepted beat with s_last=1, including when that beat is word DEPTH-1.
REQ-022 LOAD -> ERR SHALL occur on an accepted beat with s_last=0 that brings word_count to DEPTH; that word is still written.
REQ-023 HOLD SHALL last exactly HOLD_CYCLES cycles via a down-counter, then go to RUN.
REQ-024 core_reset SHALL be 1 in LOAD, HOLD, ERR and 0 in RUN; load_done SHALL be 1 only in RUN; load_err SHALL be 1 only in ERR.
REQ-025 reload=1 in RUN, HOLD or ERR SHALL, next cycle, enter LOAD with word_count=0, core_reset=1, load_done=0, load_err=0; reload in LOAD SHALL be ignored.
REQ-026 s_valid in HOLD, RUN, ERR SHALL be ignored (s_ready=0); no write, no count change.
REQ-027 word_count SHALL saturate at DEPTH and never wrap.

Reset
REQ-028 While reset=0, state SHALL be LOAD, word_count=0, im_we=0, im_addr=0, im_wdata=0, core_reset=1, load_done=0, load_err=0, HOLD counter=0, independent of clk.
REQ-029 reset=0 asserted mid-load or mid-HOLD SHALL abort immediately; after release, loading restarts at address 0.

Verification
REQ-030 Load 3 words 0x3C010000, 0x34210001, 0x00000000 (last on third), s_valid held 1 -> im_we pulses at addr 0,1,2 with those data; word_count=3; core_reset falls exactly 4 cycles after the third write cycle; load_done=1.
REQ-031 Same 3 words with s_valid toggling 1/0 each cycle -> identical writes at addr 0,1,2, no extra im_we pulses, word_count=3.
REQ-032 ADDR_W=2: 4 words with s_last=0 -> 4 writes at addr 0..3, load_err=1, s_ready=0, core_reset stays 1; 5th offered word not written; repeat with s_last=1 on 4th -> HOLD/RUN, load_err=0.
REQ-033 In RUN, pulse reload, then load 1 word 0xFFFFFFFF with s_last=1 -> core_reset rises next cycle, write at addr 0, word_count=1, RUN after HOLD.
REQ-034 Drop reset asynchronously after 2 of 5 words -> all outputs at reset values before next clock edge; after release, next word writes addr 0.
REQ-035 s_valid=1 with data in RUN and ERR for 10 cycles -> no im_we, word_count unchanged.
